// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative unsigned MUL/MULHU/DIVU/REMU unit sharing one shift/add-subtract accumulator
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]         state, state_nxt, op;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   divisor, run_res, dz_res;
    logic [2*WIDTH:0]   acc, step;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [WIDTH+1:0]   diff;
    logic               accept, last;
    // acc holds {0, product} for multiply and {remainder, quotient} for divide; both start as {0, rs1}
    always_comb begin
        accept    = state == IDLE && start_i && !flush_i;
        last      = cnt == CW'(WIDTH - 1);
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
        rem_sh    = acc[2*WIDTH-1:WIDTH-1];
        diff      = {1'b0, rem_sh} - {2'b0, divisor};
        step      = op[1] ? (diff[WIDTH+1] ? {rem_sh, acc[WIDTH-2:0], 1'b0}
                                           : {diff[WIDTH:0], acc[WIDTH-2:0], 1'b1})
                          : {1'b0, mul_sum, acc[WIDTH-1:1]};
        run_res   = op[0] ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
        dz_res    = op_i[0] ? rs1_i : '1;
        state_nxt = flush_i ? IDLE
                  : accept ? ((op_i[1] && rs2_i == '0) ? DONE : RUN)
                  : state == RUN ? (last ? DONE : RUN)
                  : IDLE;
        stall_o   = !flush_i && (state == RUN || (state == IDLE && start_i));
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            op       <= '0;
            divisor  <= '0;
            acc      <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            state  <= state_nxt;
            busy_o <= state_nxt == RUN;
            done_o <= state_nxt == DONE;
            if (accept) begin
                op      <= op_i;
                divisor <= rs2_i;
                acc     <= {{(WIDTH+1){1'b0}}, rs1_i};
                cnt     <= '0;
            end else if (state == RUN) begin
                acc <= step;
                cnt <= cnt + 1'b1;
            end
            if (accept && state_nxt == DONE)
                result_o <= dz_res;
            else if (state == RUN && state_nxt == DONE)
                result_o <= run_res;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors with hand-computed results, latency and stall/busy checks
module tb_muldiv_sequencer;
    logic        clk = 1'b0, rst_i = 1'b0, start_i = 1'b0, flush_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs1_i = '0, rs2_i = '0;
    logic        stall_o, busy_o, done_o;
    logic [31:0] result_o;
    int n_cmp = 0, n_err = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i), .op_i(op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .stall_o(stall_o), .busy_o(busy_o),
        .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat, run_cycles;
        @(negedge clk);
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
        #1 chk({tag, "_stall_acc"}, 32'(stall_o), 32'd1);
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        run_cycles = 0;
        while (!done_o && lat < 60) begin
            if (busy_o && stall_o) run_cycles++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, result_o, exp);
        chk({tag, "_run"}, 32'(run_cycles), 32'(exp_lat - 1));
        chk({tag, "_stall_done"}, 32'(stall_o), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
        chk({tag, "_hold"}, result_o, exp);
    endtask

    initial begin
        int dones;
        #1;
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_res", result_o, 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;

        run_op("mul7x6",   2'b00, 32'd7, 32'd6, 32'h0000002A, 33);
        run_op("mul_ff",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
        run_op("mulhu_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mulhu_sm", 2'b01, 32'h00010000, 32'h00030000, 32'h00000003, 33);
        run_op("divu100",  2'b10, 32'd100, 32'd7, 32'h0000000E, 33);
        run_op("remu100",  2'b11, 32'd100, 32'd7, 32'h00000002, 33);
        run_op("divu_msb", 2'b10, 32'h80000000, 32'd1, 32'h80000000, 33);
        run_op("remu_big", 2'b11, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 33);
        run_op("divu_z",   2'b10, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        run_op("remu_z",   2'b11, 32'd5, 32'd0, 32'h00000005, 1);

        // flush a MUL at cycle 10
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; rs1_i = 32'd7; rs2_i = 32'd6;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        #1 chk("flush_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        dones = 0;
        repeat (40) begin
            if (done_o) dones++;
            @(negedge clk);
        end
        chk("flush_nodone", 32'(dones), 32'd0);
        chk("flush_res", result_o, 32'h00000005);
        chk("flush_busy", 32'(busy_o), 32'd0);
        run_op("divu9_2", 2'b10, 32'd9, 32'd2, 32'h00000004, 33);

        // asynchronous reset at cycle 15 of a DIVU
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b10; rs1_i = 32'd50; rs2_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (14) @(negedge clk);
        chk("mid_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("arst_done", 32'(done_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_res", result_o, 32'd0);
        chk("arst_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        dones = 0;
        repeat (40) begin
            if (done_o) dones++;
            @(negedge clk);
        end
        chk("arst_nodone", 32'(dones), 32'd0);

        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; rs1_i = 32'd3; rs2_i = 32'd3;
        #1 chk("sf_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        chk("sf_busy", 32'(busy_o), 32'd0);
        dones = 0;
        repeat (40) begin
            if (done_o || busy_o) dones++;
            @(negedge clk);
        end
        chk("sf_noaccept", 32'(dones), 32'd0);
        chk("sf_res", result_o, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer for the EX stage of the 32-bit RISC-V pipeline. It accepts one unsigned M-extension operation (MUL, MULHU, DIVU, REMU) from the decode/execute path. It runs a single shared 2·WIDTH-bit shift/add-subtract datapath for WIDTH iterations and stalls the pipeline until the result is ready. It also handles the RISC-V divide-by-zero corner case and pipeline flushes.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  request a new operation; sampled only in IDLE.
- flush_i  input  1  abort any in-flight operation (branch/exception flush).
- op_i  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
- rs1_i  input  WIDTH  multiplicand / dividend, captured on accept.
- rs2_i  input  WIDTH  multiplier / divisor, captured on accept.
- stall_o  output  1  pipeline freeze request.
- busy_o  output  1  registered; high while in RUN.
- done_o  output  1  registered one-cycle pulse; result_o valid.
- result_o  output  WIDTH  registered result; held until next done_o.

## Operation
- Unsigned operations only; signed variants are out of scope.
- States: IDLE, RUN, DONE.
- Accept: IDLE & start_i & ~flush_i.
  - Latch op_i, rs1_i, rs2_i.
  - Clear the iteration counter.
  - Go to RUN, or to DONE directly if the op is DIVU/REMU and rs2_i == 0.
- RUN, multiply:
  - 2·WIDTH-bit product register is initialised to {0, rs1}.
  - Each iteration: if LSB = 1, add rs2 to the upper half (with carry), then shift right by 1.
- RUN, divide:
  - Restoring division with a WIDTH+1-bit partial remainder.
  - Each iteration: shift {rem, quot} left by 1 and trial-subtract rs2.
  - Keep the difference and set the quotient bit to 1 if it is non-negative, else restore.
- Counter runs 0..WIDTH-1. When the counter reaches WIDTH-1, go to DONE on the next edge.
- DONE, result selection:
  - MUL: product[WIDTH-1:0].
  - MULHU: product[2·WIDTH-1:WIDTH].
  - DIVU: quotient.
  - REMU: remainder.
  - Divide by zero: DIVU = all ones; REMU = latched rs1.
- DONE lasts one cycle (done_o = 1), then returns to IDLE.
- start_i in DONE is ignored; the pipeline re-issues it after the stall drops.
- stall_o (combinational) = (IDLE & start_i & ~flush_i) | RUN | (DONE & 0).
  - The stall covers the accept cycle.
  - The stall is released in the DONE cycle so the EX stage consumes result_o.
- flush_i in RUN or DONE:
  - Next state is IDLE.
  - No done_o is issued and result_o is unchanged.
  - stall_o drops in the same cycle flush_i is high.
- start_i while in RUN is ignored; the operands are already latched.
- Simultaneous start_i & flush_i in IDLE: flush wins; the request is not accepted.
- Reset values:
  - state IDLE, counter 0, operand/product registers 0.
  - result_o 0, done_o 0, busy_o 0.
  - stall_o 0 (with start_i low).
- Reset mid-operation returns to IDLE immediately (asynchronous). No done_o is issued afterwards.

## Timing
- Cycle 0: accept edge, with stall_o high during cycle 0.
- Cycles 1..WIDTH: RUN, with busy_o and stall_o high.
- Cycle WIDTH+1: DONE, with done_o high, result_o valid and stall_o low.
- Normal latency is WIDTH+1 cycles from accept to done_o, i.e. 33 cycles for WIDTH=32.
- Divide-by-zero latency is 1 cycle: done_o is high in cycle 1 and busy_o never rises.
- Back-to-back issue: the earliest next accept is the cycle after DONE.
- result_o changes only on the edge entering DONE.

## Test plan
- MUL 7 × 6: start in cycle 0 → done_o in cycle 33 with result_o 0x0000002A; stall_o high in cycles 0–32 and low in cycle 33.
- MUL then MULHU with 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001, then 0xFFFFFFFE; each takes 33 cycles and there is no overlap.
- DIVU 100 / 7 → 0x0000000E; REMU 100 / 7 → 0x00000002; DIVU 0x80000000 / 1 → 0x80000000.
- Divide by zero: DIVU 5 / 0 → done_o in cycle 1 with 0xFFFFFFFF; REMU 5 / 0 → 0x00000005; busy_o stays 0.
- flush_i for one cycle at cycle 10 of a MUL → stall_o low that cycle, no done_o, result_o unchanged; a following DIVU 9 / 2 returns 4 at the normal latency.
- rst_i low at cycle 15 of a DIVU → all outputs 0 immediately and no done_o. After release, start_i and flush_i both high in IDLE → not accepted and stall_o low.
